// File: rtl/servo_pwm_pkg.sv
`default_nettype none
// =============================================================================
// Module   : servo_pwm_pkg
// Desc     : Shared timing helpers for the multi-channel servo PWM block.
// Revision : 1.0 - initial release
// =============================================================================
package servo_pwm_pkg;

    typedef enum logic [1:0] {
        SLEW_HOLD = 2'd0,
        SLEW_UP   = 2'd1,
        SLEW_DOWN = 2'd2
    } slew_dir_e;

    localparam int C_HZ_PER_MHZ = 1_000_000;

    // Ceiling log2, never below 1 so single-channel selects still have a bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int period_cyc(input int clk_hz, input int time_us);
        return (clk_hz / C_HZ_PER_MHZ) * time_us;
    endfunction

    function automatic int deg_cyc(input int clk_hz, input int min_us,
                                   input int max_us, input int max_angle);
        return (period_cyc(clk_hz, max_us) - period_cyc(clk_hz, min_us)) / max_angle;
    endfunction

    function automatic int clamp_angle(input int angle, input int max_angle);
        return (angle > max_angle) ? max_angle : angle;
    endfunction

endpackage
`default_nettype wire

// File: rtl/servo_pwm_ch.sv
`default_nettype none
// =============================================================================
// Module   : servo_pwm_ch
// Desc     : One servo channel: target/current angle, slew step, width latch
//            and pulse comparator against the shared frame counter.
// Revision : 1.0 - initial release
// =============================================================================
module servo_pwm_ch
    import servo_pwm_pkg::*;
#(
    parameter int ANGLE_W     = 9,
    parameter int CNT_W       = 20,
    parameter int PERIOD_CYC  = 1_000_000,
    parameter int OFFSET_CYC  = 0,
    parameter int MIN_CYC     = 25_000,
    parameter int DEG_CYC     = 555,
    parameter int SLEW_DEG    = 180,
    parameter int RESET_ANGLE = 90
) (
    input  logic               sclk_i,
    input  logic               rst_i,
    input  logic [CNT_W-1:0]   cnt_i,
    input  logic               tgt_we_i,
    input  logic [ANGLE_W-1:0] tgt_i,
    output logic               pwm_o,
    output logic               at_target_o
);

    localparam int                 WID_W       = CNT_W + 1;
    localparam logic [CNT_W-1:0]   C_OFFSET    = CNT_W'(OFFSET_CYC);
    localparam logic [ANGLE_W-1:0] C_SLEW      = ANGLE_W'(clamp_angle(SLEW_DEG, (1 << ANGLE_W) - 1));
    localparam logic [WID_W-1:0]   C_MIN       = WID_W'(MIN_CYC);
    localparam logic [WID_W-1:0]   C_DEG       = WID_W'(DEG_CYC);
    localparam logic [ANGLE_W-1:0] C_RST_ANGLE = ANGLE_W'(RESET_ANGLE);
    localparam logic [WID_W-1:0]   C_RST_WIDTH = WID_W'(MIN_CYC + RESET_ANGLE * DEG_CYC);

    logic [ANGLE_W-1:0] cur_q, cur_d;
    logic [ANGLE_W-1:0] tgt_q, tgt_d;
    logic [WID_W-1:0]   width_q, width_d;
    logic               pwm_q, pwm_d;
    logic               at_target_q, at_target_d;

    slew_dir_e          w_dir;
    logic [ANGLE_W-1:0] w_diff;
    logic [ANGLE_W-1:0] w_step;
    logic [ANGLE_W-1:0] w_cur_step;
    logic               w_tick;
    logic [CNT_W-1:0]   w_phase;

    // Phase of the counter relative to this channel's own frame start.
    if (OFFSET_CYC == 0) begin : g_aligned
        assign w_phase = cnt_i;
    end else begin : g_staggered
        localparam logic [CNT_W-1:0] C_WRAP = CNT_W'(PERIOD_CYC - OFFSET_CYC);
        assign w_phase = (cnt_i < C_OFFSET) ? (cnt_i + C_WRAP) : (cnt_i - C_OFFSET);
    end

    always_comb begin
        w_dir  = SLEW_HOLD;
        w_diff = '0;
        if (tgt_q > cur_q) begin
            w_dir  = SLEW_UP;
            w_diff = tgt_q - cur_q;
        end else if (tgt_q < cur_q) begin
            w_dir  = SLEW_DOWN;
            w_diff = cur_q - tgt_q;
        end
        w_step = (w_diff > C_SLEW) ? C_SLEW : w_diff;

        unique case (w_dir)
            SLEW_UP:   w_cur_step = cur_q + w_step;
            SLEW_DOWN: w_cur_step = cur_q - w_step;
            default:   w_cur_step = cur_q;
        endcase

        // Angle and width only move on this channel's frame tick, so a
        // pulse in flight always finishes with the width it started with.
        w_tick      = (cnt_i == C_OFFSET);
        cur_d       = w_tick ? w_cur_step : cur_q;
        width_d     = w_tick ? (C_MIN + WID_W'(w_cur_step) * C_DEG) : width_q;
        tgt_d       = tgt_we_i ? tgt_i : tgt_q;
        pwm_d       = ({1'b0, w_phase} < width_q);
        at_target_d = (cur_d == tgt_d);
    end

    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            cur_q       <= C_RST_ANGLE;
            tgt_q       <= C_RST_ANGLE;
            width_q     <= C_RST_WIDTH;
            pwm_q       <= 1'b0;
            at_target_q <= 1'b1;
        end else begin
            cur_q       <= cur_d;
            tgt_q       <= tgt_d;
            width_q     <= width_d;
            pwm_q       <= pwm_d;
            at_target_q <= at_target_d;
        end
    end

    assign pwm_o       = pwm_q;
    assign at_target_o = at_target_q;

endmodule
`default_nettype wire

// File: rtl/servo_pwm_multi.sv
`default_nettype none
// =============================================================================
// Module   : servo_pwm_multi
// Desc     : Multi-channel servo PWM: frame counter, command decode, channels.
// Options  : SERVO_PHASE_STAGGER_EN - start channel i at i*(PERIOD_CYC/CH_NUM).
// Revision : 1.0 - initial release
// =============================================================================
module servo_pwm_multi
    import servo_pwm_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 50_000_000,
    parameter int CH_NUM       = 4,
    parameter int ANGLE_W      = 9,
    parameter int MAX_ANGLE    = 180,
    parameter int RESET_ANGLE  = 90,
    parameter int PERIOD_US    = 20_000,
    parameter int MIN_PULSE_US = 500,
    parameter int MAX_PULSE_US = 2_500,
    parameter int SLEW_DEG     = 180
) (
    input  logic                      sclk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [clog2(CH_NUM)-1:0]  cmd_ch_i,
    input  logic [ANGLE_W-1:0]        cmd_angle_i,
    output logic                      cmd_err_o,
    output logic [CH_NUM-1:0]         pwm_o,
    output logic                      frame_start_o,
    output logic [CH_NUM-1:0]         at_target_o
);

    localparam int PERIOD_CYC = period_cyc(CLK_FREQ_HZ, PERIOD_US);
    localparam int MIN_CYC    = period_cyc(CLK_FREQ_HZ, MIN_PULSE_US);
    localparam int DEG_CYC    = deg_cyc(CLK_FREQ_HZ, MIN_PULSE_US, MAX_PULSE_US, MAX_ANGLE);
    localparam int CNT_W      = clog2(PERIOD_CYC);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PERIOD_CYC - 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               frame_start_q;
    logic               cmd_err_q;

    logic               w_accept;
    logic [31:0]        w_ch_ext;
    logic               w_ch_ok;
    logic               w_clamped;
    logic [ANGLE_W-1:0] w_angle;

    assign cmd_ready_o = ~rst_i;
    assign w_accept    = cmd_valid_i & cmd_ready_o;
    // Widened so the range check stays meaningful for non-power-of-two CH_NUM.
    assign w_ch_ext    = 32'(cmd_ch_i);
    assign w_ch_ok     = (w_ch_ext < 32'(CH_NUM));
    assign w_clamped   = (int'(cmd_angle_i) > MAX_ANGLE);
    assign w_angle     = ANGLE_W'(clamp_angle(int'(cmd_angle_i), MAX_ANGLE));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            frame_start_q <= (cnt_q == '0);
            cmd_err_q     <= w_accept & (w_clamped | ~w_ch_ok);
        end
    end

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
`ifdef SERVO_PHASE_STAGGER_EN
        localparam int OFFSET_CYC = gi * (PERIOD_CYC / CH_NUM);
`else
        localparam int OFFSET_CYC = 0;
`endif
        logic w_we;
        assign w_we = w_accept & w_ch_ok & (w_ch_ext == 32'(gi));

        servo_pwm_ch #(
            .ANGLE_W     (ANGLE_W),
            .CNT_W       (CNT_W),
            .PERIOD_CYC  (PERIOD_CYC),
            .OFFSET_CYC  (OFFSET_CYC),
            .MIN_CYC     (MIN_CYC),
            .DEG_CYC     (DEG_CYC),
            .SLEW_DEG    (SLEW_DEG),
            .RESET_ANGLE (RESET_ANGLE)
        ) u_ch (
            .sclk_i      (sclk_i),
            .rst_i       (rst_i),
            .cnt_i       (cnt_q),
            .tgt_we_i    (w_we),
            .tgt_i       (w_angle),
            .pwm_o       (pwm_o[gi]),
            .at_target_o (at_target_o[gi])
        );
    end

    assign frame_start_o = frame_start_q;
    assign cmd_err_o     = cmd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_multi.sv
`default_nettype none
// =============================================================================
// Module   : tb_servo_pwm_multi
// Desc     : Directed bench for servo_pwm_multi (4-channel and 3-channel/slew).
// Revision : 1.0 - initial release
// =============================================================================
module tb_servo_pwm_multi;

    localparam int CLK_HZ = 1_000_000;
    localparam int PER_US = 6000;
    localparam int P      = 6000;
`ifdef SERVO_PHASE_STAGGER_EN
    localparam int STAG   = 1;
`else
    localparam int STAG   = 0;
`endif

    logic       sclk = 1'b0;
    logic       rst  = 1'b1;

    logic       cmd_valid_a, cmd_ready_a, cmd_err_a, fs_a;
    logic [1:0] cmd_ch_a;
    logic [8:0] cmd_angle_a;
    logic [3:0] pwm_a, at_a;

    logic       cmd_valid_b, cmd_ready_b, cmd_err_b, fs_b;
    logic [1:0] cmd_ch_b;
    logic [8:0] cmd_angle_b;
    logic [2:0] pwm_b, at_b;

    int         n_chk = 0;
    int         n_err = 0;
    int         hi_a[4];
    int         hi_b[3];
    int         rise_a[4];
    int         err_a_cnt, err_b_cnt, fs_extra;
    logic [3:0] at_mid_a;
    logic [2:0] at_mid_b;

    always #5 sclk = ~sclk;

    servo_pwm_multi #(
        .CLK_FREQ_HZ (CLK_HZ),
        .CH_NUM      (4),
        .PERIOD_US   (PER_US)
    ) u_dut_a (
        .sclk_i        (sclk),
        .rst_i         (rst),
        .cmd_valid_i   (cmd_valid_a),
        .cmd_ready_o   (cmd_ready_a),
        .cmd_ch_i      (cmd_ch_a),
        .cmd_angle_i   (cmd_angle_a),
        .cmd_err_o     (cmd_err_a),
        .pwm_o         (pwm_a),
        .frame_start_o (fs_a),
        .at_target_o   (at_a)
    );

    servo_pwm_multi #(
        .CLK_FREQ_HZ (CLK_HZ),
        .CH_NUM      (3),
        .PERIOD_US   (PER_US),
        .SLEW_DEG    (10)
    ) u_dut_b (
        .sclk_i        (sclk),
        .rst_i         (rst),
        .cmd_valid_i   (cmd_valid_b),
        .cmd_ready_o   (cmd_ready_b),
        .cmd_ch_i      (cmd_ch_b),
        .cmd_angle_i   (cmd_angle_b),
        .cmd_err_o     (cmd_err_b),
        .pwm_o         (pwm_b),
        .frame_start_o (fs_b),
        .at_target_o   (at_b)
    );

`define CHK(TAG, OBS, EXP) \
    begin \
        n_chk++; \
        assert ((OBS) === (EXP)) else begin \
            n_err++; \
            $error("FAIL %s observed=%0d expected=%0d", TAG, OBS, EXP); \
        end \
    end

    // Entered on a frame_start sample; drives optional commands during that
    // cycle, profiles one whole frame, and returns on the next frame_start.
    task automatic measure(input logic va, input logic [1:0] cha, input logic [8:0] anga,
                           input logic vb, input logic [1:0] chb, input logic [8:0] angb);
        logic [3:0] prev_a;
        prev_a      = '0;
        cmd_valid_a = va;  cmd_ch_a = cha;  cmd_angle_a = anga;
        cmd_valid_b = vb;  cmd_ch_b = chb;  cmd_angle_b = angb;
        for (int i = 0; i < 4; i++) begin
            hi_a[i]   = 0;
            rise_a[i] = -1;
        end
        for (int i = 0; i < 3; i++) hi_b[i] = 0;
        err_a_cnt = 0;
        err_b_cnt = 0;
        fs_extra  = 0;
        for (int k = 0; k < P; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (pwm_a[i]) hi_a[i]++;
                if (pwm_a[i] && !prev_a[i] && rise_a[i] < 0) rise_a[i] = k;
            end
            for (int i = 0; i < 3; i++) if (pwm_b[i]) hi_b[i]++;
            prev_a = pwm_a;
            if (cmd_err_a) err_a_cnt++;
            if (cmd_err_b) err_b_cnt++;
            if (k > 0 && fs_a) fs_extra++;
            if (k == 2) begin
                at_mid_a = at_a;
                at_mid_b = at_b;
            end
            @(negedge sclk);
            cmd_valid_a = 1'b0;
            cmd_valid_b = 1'b0;
        end
        `CHK("period_fs", fs_a, 1'b1)
        `CHK("extra_fs", fs_extra, 0)
    endtask

    task automatic chk_a(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) `CHK($sformatf("%s_a%0d", tag, i), hi_a[i], e[i])
    endtask

    task automatic chk_b(input string tag, input int e0, input int e1, input int e2);
        int e[3];
        e = '{e0, e1, e2};
        for (int i = 0; i < 3; i++) `CHK($sformatf("%s_b%0d", tag, i), hi_b[i], e[i])
    endtask

    task automatic chk_rise(input string tag);
        for (int i = 0; i < 4; i++) `CHK($sformatf("%s_rise%0d", tag, i), rise_a[i], STAG * i * (P / 4))
    endtask

    initial begin
        cmd_valid_a = 1'b0; cmd_ch_a = '0; cmd_angle_a = '0;
        cmd_valid_b = 1'b0; cmd_ch_b = '0; cmd_angle_b = '0;
        rst = 1'b1;
        repeat (4) @(negedge sclk);
        `CHK("rst_pwm", pwm_a, 4'h0)
        `CHK("rst_fs", fs_a, 1'b0)
        `CHK("rst_err", cmd_err_a, 1'b0)
        `CHK("rst_at_a", at_a, 4'hF)
        `CHK("rst_at_b", at_b, 3'h7)
        `CHK("rst_ready", cmd_ready_a, 1'b0)

        rst = 1'b0;
        #1;
        `CHK("ready", cmd_ready_a, 1'b1)
        @(negedge sclk);
        `CHK("first_fs", fs_a, 1'b1)

        // F1: commands on the frame_start cycle must not alter this frame.
        measure(1'b1, 2'd1, 9'd0, 1'b1, 2'd0, 9'd0);
        chk_rise("f1");
`ifndef SERVO_PHASE_STAGGER_EN
        chk_a("f1", 1490, 1490, 1490, 1490);
        chk_b("f1", 1490, 1490, 1490);
        `CHK("f1_err_a", err_a_cnt, 0)
        `CHK("f1_at_a", at_mid_a, 4'b1101)
        `CHK("f1_at_b", at_mid_b, 3'b110)

        // F2: ch1 now at 0 deg; B slews 90->80; B addresses missing channel 3.
        measure(1'b1, 2'd2, 9'd180, 1'b1, 2'd3, 9'd0);
        chk_a("f2", 1490, 500, 1490, 1490);
        chk_b("f2", 1380, 1490, 1490);
        `CHK("f2_err_a", err_a_cnt, 0)
        `CHK("f2_err_b", err_b_cnt, 1)
        `CHK("f2_at_a", at_mid_a, 4'b1011)
        `CHK("f2_at_b", at_mid_b, 3'b110)

        // F3: out-of-range angle on ch3 clamps to 180.
        measure(1'b1, 2'd3, 9'd250, 1'b0, 2'd0, 9'd0);
        chk_a("f3", 1490, 500, 2480, 1490);
        chk_b("f3", 1270, 1490, 1490);
        `CHK("f3_err_a", err_a_cnt, 1)
        `CHK("f3_at_a", at_mid_a, 4'b0111)

        measure(1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 9'd0);
        chk_a("f4", 1490, 500, 2480, 2480);
        chk_b("f4", 1160, 1490, 1490);
        `CHK("f4_at_a", at_mid_a, 4'hF)

        for (int f = 5; f <= 10; f++) begin
            `CHK($sformatf("f%0d_at_b0", f), at_b[0], (f == 10))
            measure(1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 9'd0);
            `CHK($sformatf("f%0d_w_b0", f), hi_b[0], 1490 - 110 * (f - 1))
        end

        repeat (700) @(negedge sclk);
        `CHK("pre_rst_pwm", pwm_a, 4'b1101)
`else
        repeat (700) @(negedge sclk);
`endif
        rst = 1'b1;
        @(negedge sclk);
        `CHK("midrst_pwm", pwm_a, 4'h0)
        `CHK("midrst_fs", fs_a, 1'b0)
        repeat (2) @(negedge sclk);
        `CHK("midrst_at", at_a, 4'hF)
        `CHK("midrst_err", cmd_err_a, 1'b0)
        rst = 1'b0;
        @(negedge sclk);
        `CHK("restart_fs", fs_a, 1'b1)
        measure(1'b0, 2'd0, 9'd0, 1'b0, 2'd0, 9'd0);
        chk_a("restart", 1490, 1490, 1490, 1490);
        chk_rise("restart");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

`undef CHK

endmodule
`default_nettype wire
